// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle for one elastic pipeline stage.
// Carries both the upstream (in_*) and the downstream (out_*) sides, so a
// single instance wires a stage to its producer and its consumer.
//   in_valid/in_data/in_ctrl   : producer -> stage
//   in_ready                   : stage -> producer (registered in the stage)
//   out_valid/out_data/out_ctrl: stage -> consumer
//   out_ready                  : consumer -> stage
// Modports:
//   slave  : the stage's view
//   master : the surrounding pipeline's (or a bench's) view
interface pipe_stage_skid_if #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned CTRL_WIDTH = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic [CTRL_WIDTH-1:0] in_ctrl;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [CTRL_WIDTH-1:0] out_ctrl;

   modport slave (
      input  in_valid, in_data, in_ctrl, out_ready,
      output in_ready, out_valid, out_data, out_ctrl
   );

   modport master (
      output in_valid, in_data, in_ctrl, out_ready,
      input  in_ready, out_valid, out_data, out_ctrl
   );
endinterface

// File: rtl/pipe_stage_skid.sv
// Generic elastic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// A main entry drives the outputs; a skid entry absorbs the one item that can
// arrive in the cycle backpressure appears, so in_ready is a plain flop and
// never depends combinationally on out_ready.
// Payload halves:
//   data : addresses/results, cleared by reset only
//   ctrl : side-effect enables, cleared by reset, flush and whenever invalid
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (priority over flush/clr_cnt)
//   flush     synchronous kill of all held entries
//   clr_cnt   synchronous clear of stall_cnt
//   stall_cnt saturating count of cycles with out_valid=1 and out_ready=0
//   bus       handshake bundle (slave view), see pipe_stage_skid_if
module pipe_stage_skid #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned CTRL_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 clr_cnt,
   output logic [CNT_WIDTH-1:0] stall_cnt,
   pipe_stage_skid_if.slave     bus
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] main_data;
   logic [CTRL_WIDTH-1:0] main_ctrl;
   logic [DATA_WIDTH-1:0] skid_data;
   logic [CTRL_WIDTH-1:0] skid_ctrl;
   logic                  in_ready_q;
   logic                  out_valid_q;
   logic                  accept;
   logic                  pop;

   always_comb begin
      accept = bus.in_valid & in_ready_q;
      pop    = out_valid_q & bus.out_ready;
   end

   // in_ready/out_valid are dedicated flops updated alongside the state, so
   // they always equal (state != FULL) and (state != EMPTY) respectively.
   // ctrl fields are cleared whenever their entry goes invalid, which keeps
   // out_ctrl at zero without any output gating.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= EMPTY;
         main_data   <= '0;
         main_ctrl   <= '0;
         skid_data   <= '0;
         skid_ctrl   <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else if (flush) begin
         // Data halves are left as-is; an item accepted this cycle is dropped.
         state       <= EMPTY;
         main_ctrl   <= '0;
         skid_ctrl   <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  main_data   <= bus.in_data;
                  main_ctrl   <= bus.in_ctrl;
                  out_valid_q <= 1'b1;
                  state       <= ONE;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  main_data <= bus.in_data;
                  main_ctrl <= bus.in_ctrl;
               end else if (accept) begin
                  skid_data  <= bus.in_data;
                  skid_ctrl  <= bus.in_ctrl;
                  in_ready_q <= 1'b0;
                  state      <= FULL;
               end else if (pop) begin
                  main_ctrl   <= '0;
                  out_valid_q <= 1'b0;
                  state       <= EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  main_data  <= skid_data;
                  main_ctrl  <= skid_ctrl;
                  skid_ctrl  <= '0;
                  in_ready_q <= 1'b1;
                  state      <= ONE;
               end
            end
            default: begin
               state       <= EMPTY;
               main_ctrl   <= '0;
               skid_ctrl   <= '0;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr_cnt) begin
         stall_cnt <= '0;
      end else if (out_valid_q && !bus.out_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end
   end

   always_comb begin
      bus.in_ready  = in_ready_q;
      bus.out_valid = out_valid_q;
      bus.out_data  = main_data;
      bus.out_ctrl  = main_ctrl;
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomised self-checking bench for pipe_stage_skid.
// The DUT is built with a 2-bit stall counter so saturation is reachable.
module tb_pipe_stage_skid;

   localparam int unsigned DW = 16;
   localparam int unsigned CW = 8;
   localparam int unsigned NW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          clr_cnt;
   logic [NW-1:0] stall_cnt;

   int unsigned total  = 0;
   int unsigned passed = 0;

   pipe_stage_skid_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();

   pipe_stage_skid #(
      .DATA_WIDTH(DW),
      .CTRL_WIDTH(CW),
      .CNT_WIDTH (NW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .clr_cnt  (clr_cnt),
      .stall_cnt(stall_cnt),
      .bus      (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [CW-1:0] mk_ctrl(input logic [DW-1:0] d);
      return {1'b1, d[6:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Advance one clock and sample 1 time unit after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [DW-1:0] d);
      bus.in_valid = v;
      bus.in_data  = d;
      bus.in_ctrl  = v ? mk_ctrl(d) : '0;
   endtask

   logic [DW-1:0] sb[$];
   logic [DW-1:0] head;
   logic [DW-1:0] next_id;
   logic          acc;
   logic          pp;
   logic [NW-1:0] stall_exp[6];

   initial begin
      rst           = 1'b1;
      flush         = 1'b0;
      clr_cnt       = 1'b0;
      bus.out_ready = 1'b0;
      drive(1'b0, '0);
      cyc();
      cyc();
      // Reset state
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_data",  64'(bus.out_data),  64'd0);
      chk("rst_out_ctrl",  64'(bus.out_ctrl),  64'd0);
      chk("rst_stall_cnt", 64'(stall_cnt),     64'd0);
      chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
      rst = 1'b0;

      // Pass-through, back-to-back
      bus.out_ready = 1'b1;
      drive(1'b1, 16'h0011); cyc();
      chk("pt_0x11", 64'(bus.out_data), 64'h11);
      chk("pt_ctrl_0x11", 64'(bus.out_ctrl), 64'(mk_ctrl(16'h0011)));
      chk("pt_rdy1", 64'(bus.in_ready), 64'd1);
      drive(1'b1, 16'h0022); cyc();
      chk("pt_0x22", 64'(bus.out_data), 64'h22);
      chk("pt_rdy2", 64'(bus.in_ready), 64'd1);
      drive(1'b1, 16'h0033); cyc();
      chk("pt_0x33", 64'(bus.out_data), 64'h33);
      chk("pt_valid3", 64'(bus.out_valid), 64'd1);
      drive(1'b0, '0); cyc();
      chk("pt_drain_valid", 64'(bus.out_valid), 64'd0);
      chk("pt_drain_ctrl",  64'(bus.out_ctrl),  64'd0);
      chk("pt_stall_none",  64'(stall_cnt),     64'd0);

      // Skid fill then drain
      bus.out_ready = 1'b0;
      drive(1'b1, 16'h000A); cyc();
      chk("sk_one_data", 64'(bus.out_data), 64'hA);
      chk("sk_one_rdy",  64'(bus.in_ready), 64'd1);
      drive(1'b1, 16'h000B); cyc();
      chk("sk_full_rdy",  64'(bus.in_ready), 64'd0);
      chk("sk_full_data", 64'(bus.out_data), 64'hA);
      chk("sk_full_stall", 64'(stall_cnt),   64'd1);
      drive(1'b0, '0);
      bus.out_ready = 1'b1;
      cyc();
      chk("sk_pop1_data", 64'(bus.out_data), 64'hB);
      chk("sk_pop1_ctrl", 64'(bus.out_ctrl), 64'(mk_ctrl(16'h000B)));
      chk("sk_pop1_rdy",  64'(bus.in_ready), 64'd1);
      cyc();
      chk("sk_empty_valid", 64'(bus.out_valid), 64'd0);
      chk("sk_empty_ctrl",  64'(bus.out_ctrl),  64'd0);

      // Flush while FULL with a pending input
      bus.out_ready = 1'b0;
      drive(1'b1, 16'h000D); cyc();
      drive(1'b1, 16'h000E); cyc();
      chk("fl_full_rdy", 64'(bus.in_ready), 64'd0);
      drive(1'b1, 16'h000C);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      drive(1'b0, '0);
      chk("fl_valid", 64'(bus.out_valid), 64'd0);
      chk("fl_ctrl",  64'(bus.out_ctrl),  64'd0);
      chk("fl_rdy",   64'(bus.in_ready),  64'd1);
      bus.out_ready = 1'b1;
      cyc();
      chk("fl_no_0xC", 64'(bus.out_valid), 64'd0);

      // Flush in ONE while an input is accepted: input discarded, data kept
      drive(1'b1, 16'h0044); bus.out_ready = 1'b0; cyc();
      drive(1'b1, 16'h0055);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      drive(1'b0, '0);
      chk("fl1_valid",     64'(bus.out_valid), 64'd0);
      chk("fl1_data_kept", 64'(bus.out_data),  64'h44);
      cyc();
      chk("fl1_no_0x55", 64'(bus.out_valid), 64'd0);

      // Reset mid-stream while FULL
      drive(1'b1, 16'h0001); cyc();
      drive(1'b1, 16'h0002); cyc();
      chk("rm_full_rdy", 64'(bus.in_ready), 64'd0);
      drive(1'b0, '0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rm_valid", 64'(bus.out_valid), 64'd0);
      chk("rm_data",  64'(bus.out_data),  64'd0);
      chk("rm_ctrl",  64'(bus.out_ctrl),  64'd0);
      chk("rm_stall", 64'(stall_cnt),     64'd0);
      chk("rm_rdy",   64'(bus.in_ready),  64'd1);
      drive(1'b1, 16'h0005); cyc();
      drive(1'b0, '0);
      chk("rm_push5_valid", 64'(bus.out_valid), 64'd1);
      chk("rm_push5_data",  64'(bus.out_data),  64'h5);

      // Saturating stall counter (0x5 is held with out_ready=0)
      clr_cnt = 1'b1; cyc(); clr_cnt = 1'b0;
      chk("cnt_clr0", 64'(stall_cnt), 64'd0);
      stall_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk($sformatf("cnt_step%0d", i), 64'(stall_cnt), 64'(stall_exp[i]));
      end
      chk("cnt_hold_data", 64'(bus.out_data), 64'h5);
      clr_cnt = 1'b1; cyc(); clr_cnt = 1'b0;
      chk("cnt_clr_prio", 64'(stall_cnt), 64'd0);
      cyc();
      chk("cnt_restart", 64'(stall_cnt), 64'd1);
      bus.out_ready = 1'b1; cyc();
      chk("cnt_drain_valid", 64'(bus.out_valid), 64'd0);

      // Randomised traffic against a FIFO scoreboard
      next_id = 16'h0100;
      for (int n = 0; n < 10000; n++) begin
         chk("rnd_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
         chk("rnd_rdy",   64'(bus.in_ready),  64'(sb.size() < 2));
         if (!bus.out_valid)
            chk("rnd_ctrl_inv", 64'(bus.out_ctrl), 64'd0);
         drive(($urandom_range(0, 3) != 0), next_id);
         bus.out_ready = ($urandom_range(0, 1) != 0);
         flush         = ($urandom_range(0, 31) == 0);
         acc = bus.in_valid & bus.in_ready;
         pp  = bus.out_valid & bus.out_ready;
         if (pp && sb.size() != 0) begin
            head = sb.pop_front();
            chk("rnd_data", 64'(bus.out_data), 64'(head));
            chk("rnd_ctrl", 64'(bus.out_ctrl), 64'(mk_ctrl(head)));
         end
         if (flush) sb.delete();
         else if (acc) sb.push_back(next_id);
         if (acc) next_id = next_id + 16'd1;
         cyc();
      end
      flush = 1'b0;
      drive(1'b0, '0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
